// File: rtl/if_id_pkg.sv
// if_id_pkg: shared constants for the IF/ID elastic buffer.
//   Instruction field offsets and widths, the NOP bubble encoding, the
//   PC increment, and the reference layout of one buffered entry.
package if_id_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned OPC_W     = 6;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned JMP_W     = 26;
  localparam int unsigned MAX_DEPTH = 8;

  // sll $0,$0,0 -- presented whenever the buffer is empty
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned        PC_INC    = 4;

  // Entry layout for the default 32-bit PC; the top packs the same
  // {instr, pc} order into a flat vector sized by its PC_W parameter.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// if_id_fifo: DEPTH-entry circular buffer with pointer/count bookkeeping.
//   clk, rst      : clock, asynchronous active-high reset of pointers/count
//   push, pop     : caller-qualified write / read-advance strobes
//   clear         : synchronous empty; overrides push and pop
//   wr_data       : entry written on push
//   rd_data       : entry at the read pointer (head)
//   count         : occupancy 0..DEPTH
// Storage itself is never reset; consumers must gate on count.
module if_id_fifo #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned W        = 64,
  parameter int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [W-1:0]        wr_data,
  output logic [W-1:0]        rd_data,
  output logic [CNT_BITS-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-2 depths never index past the array
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/if_id_stage_buf.sv
// if_id_stage_buf: DEPTH-entry elastic IF/ID buffer with head decode.
//   clk, reset_in          : clock, asynchronous active-high reset
//   enable, flush          : global advance, squash (empties buffer)
//   in_valid/in_ready      : fetch handshake; in_ready = count<DEPTH
//   Instruction_memory_in, PC_in : fetched word and its address
//   out_valid/out_ready    : decode handshake; out_valid = count>0
//   *_out fields           : head instruction fields, all 0 when empty
//   PC_Counter_out         : head PC + 4, 0 when empty
// Optional macro IF_ID_PERF_EN adds saturating stall_cnt_out and
// bubble_cnt_out (CNT_W bits), cleared only by reset_in.
module if_id_stage_buf
  import if_id_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              enable,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instruction_memory_in,
  input  logic [PC_W-1:0]   PC_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        Op_code_out,
  output logic [4:0]        Read_Reg_1_out,
  output logic [4:0]        IF_ID_Rs_out,
  output logic [4:0]        Rs_Hazard_out,
  output logic [4:0]        Read_Reg_2_out,
  output logic [4:0]        IF_ID_Rt_out,
  output logic [4:0]        Rt_Hazard_out,
  output logic [4:0]        IF_ID_Rd_out,
  output logic [5:0]        Funct_out,
  output logic [15:0]       sign_extend_input_out,
  output logic [25:0]       Jump_Offset_out,
  output logic [PC_W-1:0]   PC_Counter_out
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_out,
  output logic [CNT_W-1:0]  bubble_cnt_out
`endif
);

  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W    = INSTR_W + PC_W;

  if (DEPTH < 1 || DEPTH > MAX_DEPTH || CNT_W < 1) begin : g_param_chk
    $error("if_id_stage_buf: DEPTH must be 1..8 and CNT_W >= 1");
  end

  logic                push, pop;
  logic [ENT_W-1:0]    wr_entry, rd_entry;
  logic [CNT_BITS-1:0] count;
  logic [INSTR_W-1:0]  head_instr;

  assign in_ready  = (count < CNT_BITS'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid  & in_ready  & enable & ~flush;
  assign pop       = out_valid & out_ready & enable & ~flush;
  assign wr_entry  = {Instruction_memory_in, PC_in};

  if_id_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_in),
    .push    (push),
    .pop     (pop),
    .clear   (flush),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (count)
  );

  // Gate on out_valid so unreset storage never leaks to decode
  always_comb begin
    head_instr     = NOP_INSTR;
    PC_Counter_out = '0;
    if (out_valid) begin
      head_instr     = rd_entry[ENT_W-1 -: INSTR_W];
      PC_Counter_out = rd_entry[PC_W-1:0] + PC_W'(PC_INC);
    end
  end

  assign Op_code_out           = head_instr[OPC_LSB +: OPC_W];
  assign Read_Reg_1_out        = head_instr[RS_LSB +: REG_W];
  assign IF_ID_Rs_out          = head_instr[RS_LSB +: REG_W];
  assign Rs_Hazard_out         = head_instr[RS_LSB +: REG_W];
  assign Read_Reg_2_out        = head_instr[RT_LSB +: REG_W];
  assign IF_ID_Rt_out          = head_instr[RT_LSB +: REG_W];
  assign Rt_Hazard_out         = head_instr[RT_LSB +: REG_W];
  assign IF_ID_Rd_out          = head_instr[RD_LSB +: REG_W];
  assign Funct_out             = head_instr[FUNCT_W-1:0];
  assign sign_extend_input_out = head_instr[IMM_W-1:0];
  assign Jump_Offset_out       = head_instr[JMP_W-1:0];

`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (in_valid && !in_ready && enable && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!out_valid && out_ready && enable && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_out  = stall_cnt_q;
  assign bubble_cnt_out = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage_buf.sv
module tb_if_id_stage_buf;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset_in = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        in_ready, out_valid;
  logic [5:0]  opc, funct;
  logic [4:0]  rr1, rs, rs_hz, rr2, rt, rt_hz, rd;
  logic [15:0] imm;
  logic [25:0] jmp;
  logic [31:0] pc_out;
`ifdef IF_ID_PERF_EN
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  if_id_stage_buf #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk                   (clk),
    .reset_in              (reset_in),
    .enable                (enable),
    .flush                 (flush),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .Instruction_memory_in (instr_in),
    .PC_in                 (pc_in),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .Op_code_out           (opc),
    .Read_Reg_1_out        (rr1),
    .IF_ID_Rs_out          (rs),
    .Rs_Hazard_out         (rs_hz),
    .Read_Reg_2_out        (rr2),
    .IF_ID_Rt_out          (rt),
    .Rt_Hazard_out         (rt_hz),
    .IF_ID_Rd_out          (rd),
    .Funct_out             (funct),
    .sign_extend_input_out (imm),
    .Jump_Offset_out       (jmp),
    .PC_Counter_out        (pc_out)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt_out         (stall_cnt),
    .bubble_cnt_out        (bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        exp_q[$];
  int unsigned n_chk = 0, n_fail = 0;
  int unsigned stall_exp = 0, bubble_exp = 0;
  int unsigned sz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of accepted transactions
  always @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      exp_q.delete();
      stall_exp  = 0;
      bubble_exp = 0;
    end else begin
      sz = exp_q.size();
      if (enable && in_valid && sz >= DEPTH && stall_exp < CNT_MAX) stall_exp++;
      if (enable && out_ready && sz == 0 && bubble_exp < CNT_MAX) bubble_exp++;
      if (flush) exp_q.delete();
      else if (enable) begin
        if (out_ready && sz > 0) void'(exp_q.pop_front());
        if (in_valid && sz < DEPTH) exp_q.push_back('{ins: instr_in, pc: pc_in});
      end
    end
  end

  task automatic check_outputs();
    logic [31:0] ins, epc;
    logic        v;
    v   = (exp_q.size() > 0);
    ins = v ? exp_q[0].ins : 32'h0;
    epc = v ? exp_q[0].pc + 32'd4 : 32'h0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < DEPTH});
    chk("opcode", {26'b0, opc}, ins / 32'h0400_0000);
    chk("read_reg_1", {27'b0, rr1}, (ins >> 21) % 32);
    chk("rs", {27'b0, rs}, (ins >> 21) % 32);
    chk("rs_hazard", {27'b0, rs_hz}, (ins >> 21) % 32);
    chk("read_reg_2", {27'b0, rr2}, (ins >> 16) % 32);
    chk("rt", {27'b0, rt}, (ins >> 16) % 32);
    chk("rt_hazard", {27'b0, rt_hz}, (ins >> 16) % 32);
    chk("rd", {27'b0, rd}, (ins >> 11) % 32);
    chk("funct", {26'b0, funct}, ins % 64);
    chk("imm", {16'b0, imm}, ins % 65536);
    chk("jump_offset", {6'b0, jmp}, ins % 32'h0400_0000);
    chk("pc_counter", pc_out, epc);
`ifdef IF_ID_PERF_EN
    chk("stall_cnt", {30'b0, stall_cnt}, stall_exp);
    chk("bubble_cnt", {30'b0, bubble_cnt}, bubble_exp);
`endif
  endtask

  // Monitor: outputs change only on clock/reset, so sample on the falling edge
  initial forever begin
    @(negedge clk);
    check_outputs();
  end

  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic en, input logic fl);
    in_valid  = iv;
    instr_in  = ins;
    pc_in     = pc;
    out_ready = ordy;
    enable    = en;
    flush     = fl;
    @(negedge clk);
  endtask

  initial begin
    #1 reset_in = 1'b1;
    repeat (2) @(negedge clk);
    reset_in = 1'b0;

    // Single push, head decode and PC+4
    cyc(1'b1, 32'h8210_0000, 32'h0000_0040, 1'b0, 1'b1, 1'b0);
    chk("t1_opcode", {26'b0, opc}, 32'h20);
    chk("t1_rs", {27'b0, rs}, 32'd16);
    chk("t1_rt", {27'b0, rt}, 32'd16);
    chk("t1_pc", pc_out, 32'h44);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    // Fill to full, third held, then drain in order
    cyc(1'b1, 32'hAAAA_0001, 32'h100, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hBBBB_0002, 32'h104, 1'b0, 1'b1, 1'b0);
    chk("t2_full_in_ready", {31'b0, in_ready}, 32'd0);
    cyc(1'b1, 32'hCCCC_0003, 32'h108, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hCCCC_0003, 32'h108, 1'b1, 1'b1, 1'b0);
    chk("t2_head_b", pc_out, 32'h108);
    cyc(1'b1, 32'hCCCC_0003, 32'h108, 1'b1, 1'b1, 1'b0);
    chk("t2_head_c", pc_out, 32'h10C);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    // Flush with a same-cycle push discards everything
    cyc(1'b1, 32'h1111_1111, 32'h200, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h2222_2222, 32'h204, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'hDDDD_DDDD, 32'h208, 1'b0, 1'b1, 1'b1);
    chk("t3_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t3_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t3_pc", pc_out, 32'h0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Enable low freezes everything, then streaming resumes
    cyc(1'b1, 32'h3333_0000, 32'h300, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h4444_0000 + i, 32'h304 + 4 * i, 1'b1, 1'b0, 1'b0);
    chk("t4_frozen_pc", pc_out, 32'h304);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h5555_0000 + i, 32'h400 + 4 * i, 1'b1, 1'b1, 1'b0);

    // PC wrap, then asynchronous reset between edges
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 32'h0123_4567, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    chk("t5_pc_wrap", pc_out, 32'h0);
    chk("t5_valid", {31'b0, out_valid}, 32'd1);
    cyc(1'b1, 32'h89AB_CDEF, 32'h500, 1'b0, 1'b1, 1'b0);
    #2 reset_in = 1'b1;
    #1;
    chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("t5_rst_opcode", {26'b0, opc}, 32'd0);
    check_outputs();
    @(negedge clk);
    reset_in = 1'b0;

    // Perf stall counter saturation survives flush
    cyc(1'b1, 32'h6666_0000, 32'h600, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h6666_0001, 32'h604, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 32'h6666_0002, 32'h608, 1'b0, 1'b1, 1'b0);
`ifdef IF_ID_PERF_EN
    chk("t6_stall_sat", {30'b0, stall_cnt}, CNT_MAX);
`endif
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
`ifdef IF_ID_PERF_EN
    chk("t6_stall_after_flush", {30'b0, stall_cnt}, CNT_MAX);
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
          $urandom_range(0, 15) == 0);

    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage_buf.md
Name: if_id_stage_buf

Overview:
Parametrised successor to the single-register IF/ID latch of the 32-bit MIPS pipeline. A DEPTH-entry elastic buffer sits between fetch and decode, using a valid/ready handshake, flush and global enable. It decodes the head instruction into the register-file, hazard-unit and control fields. PC+4 is carried with each instruction, and an empty buffer presents a NOP bubble.

Parameters:
PC_W, 32, width of program counter carried with each instruction
DEPTH, 2, number of buffered entries (legal 1..8); 1 gives classic single-register behaviour
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset_in  in  1  asynchronous, active-high reset
enable  in  1  global advance; 0 freezes the buffer (no push, no pop)
flush  in  1  branch/jump squash; empties the buffer
in_valid  in  1  fetch presents an instruction
in_ready  out  1  buffer can accept; equals count<DEPTH, no combinational path from out_ready
Instruction_memory_in  in  32  fetched instruction word
PC_in  in  PC_W  address of the fetched instruction
out_valid  out  1  head entry valid (count>0)
out_ready  in  1  decode stage consumes the head
Op_code_out  out  6  head[31:26]
Read_Reg_1_out, IF_ID_Rs_out, Rs_Hazard_out  out  5 each  head[25:21]
Read_Reg_2_out, IF_ID_Rt_out, Rt_Hazard_out  out  5 each  head[20:16]
IF_ID_Rd_out  out  5  head[15:11]
Funct_out  out  6  head[5:0]
sign_extend_input_out  out  16  head[15:0]
Jump_Offset_out  out  26  head[25:0]
PC_Counter_out  out  PC_W  stored PC + 4, mod 2^PC_W

Behaviour:
- Circular buffer with wr_ptr, rd_ptr (wrap at DEPTH, including non-power-of-2 depths) and count 0..DEPTH.
- push = in_valid & in_ready & enable & ~flush.
- pop = out_valid & out_ready & enable & ~flush.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N (out_valid=1 in cycle N+1). Entries leave in FIFO order.
- Simultaneous push and pop: count unchanged, both pointers advance. At full, in_ready=0, so no push occurs even if a pop happens that cycle.
- enable=0: pointers, count and storage hold. Outputs are stable. in_ready still reflects count.
- flush=1: at the next edge, count=0 and pointers reset to 0, regardless of enable. A same-cycle push is discarded. Outputs show the NOP bubble the cycle after.
- out_valid=0: all decoded field outputs and PC_Counter_out are driven 0 (instruction 0x00000000 = sll $0,$0,0 NOP). Downstream never sees stale fields.
- Reset (asynchronous, mid-operation allowed): count=0, pointers=0, storage irrelevant. out_valid=0, in_ready=1, all field outputs 0, counters 0.
- Storage is not reset. Output gating guarantees the zero values.

Optional Feature:
IF_ID_PERF_EN
- Defined: adds outputs stall_cnt_out[CNT_W] and bubble_cnt_out[CNT_W].
  - stall_cnt_out increments each cycle with in_valid & ~in_ready & enable.
  - bubble_cnt_out increments each cycle with ~out_valid & out_ready & enable.
  - Both saturate at all-ones and clear on reset_in only, not on flush.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package if_id_pkg:
  - field offsets/widths (OPC_LSB=26, RS_LSB=21, RT_LSB=16, RD_LSB=11, IMM_W=16, JMP_W=26);
  - NOP_INSTR=32'h0000_0000;
  - PC_INC=4;
  - packed entry typedef {instr, pc}.
- One sub-module, if_id_fifo: generic DEPTH-entry storage with pointer/count logic, push, pop, clear.
- Field decode, output gating and perf counters stay in the top.

Test Plan:
1. Reset, then push instr 0x82100000, PC 0x00000040 with enable=1, out_ready=0 → next cycle out_valid=1, Op_code_out=6'h20, Rs=16, Rt=16, Rd=0, imm=16'h0000, PC_Counter_out=0x44.
2. DEPTH=2, out_ready=0, push three instrs → in_ready=0 after second push, third held. Then out_ready=1 → outputs appear in order A, B, C, one per cycle.
3. Buffer holds 2 entries; assert flush with in_valid=1 → next cycle out_valid=0, all fields 0, in_ready=1, flushed-cycle instruction never appears.
4. Hold enable=0 for 5 cycles with in_valid=out_ready=1 → outputs and count frozen. Release → exactly one push and one pop per cycle resume.
5. PC_in=0xFFFFFFFC → PC_Counter_out=0x00000000. Assert reset_in mid-stream (between edges) → outputs zero immediately, in_ready=1.
6. IF_ID_PERF_EN defined, CNT_W=2, hold full with in_valid=1 for 6 cycles → stall_cnt_out saturates at 3; flush leaves it at 3.
